// File: rtl/fifo_flex_if.sv
// Handshake and status bundle between a fifo_flex instance and its user.
interface fifo_flex_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned FD = 8
);
    localparam int unsigned CW = $clog2(FD) + 1;

    logic          ffflush;
    logic          ffwreq;
    logic [DW-1:0] ffwdata;
    logic          ffwfull;
    logic          ffafull;
    logic          ffrreq;
    logic [DW-1:0] ffrdata;
    logic          ffrvld;
    logic          ffrempty;
    logic          ffaempty;
    logic [CW-1:0] ffvcnt;
    logic          ffovf;
    logic          ffudf;
    logic          fferrclr;

    modport master (
        output ffflush, ffwreq, ffwdata, ffrreq, fferrclr,
        input  ffwfull, ffafull, ffrdata, ffrvld, ffrempty, ffaempty, ffvcnt, ffovf, ffudf
    );

    modport slave (
        input  ffflush, ffwreq, ffwdata, ffrreq, fferrclr,
        output ffwfull, ffafull, ffrdata, ffrvld, ffrempty, ffaempty, ffvcnt, ffovf, ffudf
    );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO of arbitrary depth with registered-read or first-word-fall-through
// output, programmable almost-full/almost-empty levels and sticky overflow/underflow flags.
module fifo_flex #(
    parameter int unsigned DW     = 8,
    parameter int unsigned FD     = 8,
    parameter int unsigned FWFT   = 0,
    parameter int          AF_LVL = 6,
    parameter int          AE_LVL = 2
) (
    input  logic       clk,
    input  logic       reset,
    fifo_flex_if.slave bus
);
    localparam int unsigned AW = $clog2(FD);
    localparam int unsigned CW = $clog2(FD) + 1;

    if (DW < 1 || FD < 2 || FWFT > 1 || AE_LVL < 0 || AE_LVL >= AF_LVL || AF_LVL > int'(FD)) begin : g_bad_param
        $error("fifo_flex: illegal parameters DW=%0d FD=%0d FWFT=%0d AF_LVL=%0d AE_LVL=%0d",
               DW, FD, FWFT, AF_LVL, AE_LVL);
    end

    logic [DW-1:0] mem [FD];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          udf;
    logic          full;
    logic          empty;
    logic          wacc;
    logic          racc;

    assign full  = (cnt == CW'(FD));
    assign empty = (cnt == '0);
    assign wacc  = bus.ffwreq & ~full & ~bus.ffflush;
    assign racc  = bus.ffrreq & ~empty & ~bus.ffflush;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FD - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (bus.ffflush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wacc) wptr <= ptr_inc(wptr);
            if (racc) rptr <= ptr_inc(rptr);
            if (wacc && !racc) begin
                cnt <= cnt + CW'(1);
            end else if (racc && !wacc) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Sticky error flags; a same-cycle set beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (bus.ffwreq && full && !bus.ffflush) begin
                ovf <= 1'b1;
            end else if (bus.fferrclr) begin
                ovf <= 1'b0;
            end
            if (bus.ffrreq && empty && !bus.ffflush) begin
                udf <= 1'b1;
            end else if (bus.fferrclr) begin
                udf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wacc && !reset) mem[wptr] <= bus.ffwdata;
    end

    assign bus.ffwfull  = full;
    assign bus.ffafull  = (cnt >= CW'(AF_LVL));
    assign bus.ffrempty = empty;
    assign bus.ffaempty = (cnt <= CW'(AE_LVL));
    assign bus.ffvcnt   = cnt;
    assign bus.ffovf    = ovf;
    assign bus.ffudf    = udf;

    if (FWFT == 0) begin : g_reg_read
        logic [DW-1:0] rdata;
        logic          rvld;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata <= '0;
                rvld  <= 1'b0;
            end else begin
                rvld <= racc;
                if (racc) rdata <= mem[rptr];
            end
        end

        assign bus.ffrdata = rdata;
        assign bus.ffrvld  = rvld;
    end else begin : g_fwft_read
        // Head entry is only exposed when it has been written.
        assign bus.ffrdata = empty ? '0 : mem[rptr];
        assign bus.ffrvld  = ~empty;
    end
endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a registered-read and a FWFT instance (FD=5) checked against a queue model.
module tb_fifo_flex;
    localparam int unsigned DW = 8;
    localparam int unsigned FD = 5;
    localparam int          AF = 4;
    localparam int          AE = 1;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_flex_if #(.DW(DW), .FD(FD)) b0 ();
    fifo_flex_if #(.DW(DW), .FD(FD)) b1 ();

    fifo_flex #(.DW(DW), .FD(FD), .FWFT(0), .AF_LVL(AF), .AE_LVL(AE)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    fifo_flex #(.DW(DW), .FD(FD), .FWFT(1), .AF_LVL(AF), .AE_LVL(AE)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    int vectors = 0;
    int miscompares = 0;

    bq_t        q0, q1;
    bit         ovf0, udf0, rv0, ovf1, udf1, rv1;
    logic [7:0] rd0, rd1;

    // Reference: a plain queue of stored bytes plus the flag/read-register rules.
    task automatic mstep(input bit fw, input bit fl, input bit w, input bit r, input bit clr,
                         input logic [7:0] wd, inout bq_t q, inout bit ovf, inout bit udf,
                         inout bit rv, inout logic [7:0] rd);
        bit full, empty, wacc, racc;
        full  = (q.size() == FD);
        empty = (q.size() == 0);
        wacc  = w && !full && !fl;
        racc  = r && !empty && !fl;
        if (w && full && !fl) ovf = 1'b1;
        else if (clr)         ovf = 1'b0;
        if (r && empty && !fl) udf = 1'b1;
        else if (clr)          udf = 1'b0;
        if (!fw) begin
            rv = racc;
            if (racc) rd = q[0];
        end
        if (fl) begin
            q.delete();
        end else begin
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(wd);
        end
    endtask

    function automatic logic [18:0] expv(input bit fw, input bq_t q, input bit ovf, input bit udf,
                                         input bit rv, input logic [7:0] rd);
        int sz;
        logic [7:0] d;
        bit v;
        sz = q.size();
        if (fw) begin
            v = (sz != 0);
            d = (sz != 0) ? q[0] : 8'h00;
        end else begin
            v = rv;
            d = rd;
        end
        return {4'(sz), sz == FD, sz >= AF, sz == 0, sz <= AE, ovf, udf, v, d};
    endfunction

    function automatic logic [18:0] act0();
        return {b0.ffvcnt, b0.ffwfull, b0.ffafull, b0.ffrempty, b0.ffaempty,
                b0.ffovf, b0.ffudf, b0.ffrvld, b0.ffrdata};
    endfunction

    function automatic logic [18:0] act1();
        return {b1.ffvcnt, b1.ffwfull, b1.ffafull, b1.ffrempty, b1.ffaempty,
                b1.ffovf, b1.ffudf, b1.ffrvld, b1.ffrdata};
    endfunction

    task automatic drive0(input bit fl, input bit w, input logic [7:0] wd, input bit r, input bit clr);
        b0.ffflush = fl; b0.ffwreq = w; b0.ffwdata = wd; b0.ffrreq = r; b0.fferrclr = clr;
    endtask

    task automatic drive1(input bit fl, input bit w, input logic [7:0] wd, input bit r, input bit clr);
        b1.ffflush = fl; b1.ffwreq = w; b1.ffwdata = wd; b1.ffrreq = r; b1.fferrclr = clr;
    endtask

    task automatic idle();
        drive0(0, 0, 8'h00, 0, 0);
        drive1(0, 0, 8'h00, 0, 0);
    endtask

    // Advance the model with the currently driven inputs, then one clock; sample at negedge.
    task automatic tick();
        if (reset) begin
            q0.delete(); q1.delete();
            ovf0 = 0; udf0 = 0; rv0 = 0; rd0 = 8'h00;
            ovf1 = 0; udf1 = 0; rv1 = 0; rd1 = 8'h00;
        end else begin
            mstep(0, b0.ffflush, b0.ffwreq, b0.ffrreq, b0.fferrclr, b0.ffwdata, q0, ovf0, udf0, rv0, rd0);
            mstep(1, b1.ffflush, b1.ffwreq, b1.ffrreq, b1.fferrclr, b1.ffwdata, q1, ovf1, udf1, rv1, rd1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [18:0] rst_val;
        rst_val = {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        reset = 1'b1;
        drive0(1, 1, 8'h5A, 1, 1);
        drive1(0, 1, 8'hC3, 1, 0);
        tick();
        vectors++;
        if (act0() !== rst_val) begin
            miscompares++;
            $display("FAIL reset_dut0: got %h want %h", act0(), rst_val);
        end
        vectors++;
        if (act1() !== rst_val) begin
            miscompares++;
            $display("FAIL reset_dut1: got %h want %h", act1(), rst_val);
        end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            drive0(0, 1, 8'(i), 0, 0);
            tick();
        end
        drive0(0, 1, 8'hFF, 0, 0);
        tick();
        idle();
        vectors++;
        if (b0.ffwfull !== 1'b1 || b0.ffovf !== 1'b1 || b0.ffvcnt !== 4'd5) begin
            miscompares++;
            $display("FAIL ovf_full: got full=%b ovf=%b cnt=%0d want full=1 ovf=1 cnt=5",
                     b0.ffwfull, b0.ffovf, b0.ffvcnt);
        end
        for (int i = 1; i <= 5; i++) begin
            drive0(0, 0, 8'h00, 1, 0);
            tick();
            vectors++;
            if (b0.ffrvld !== 1'b1 || b0.ffrdata !== 8'(i)) begin
                miscompares++;
                $display("FAIL ovf_read%0d: got vld=%b data=%h want vld=1 data=%h",
                         i, b0.ffrvld, b0.ffrdata, 8'(i));
            end
        end
        idle();
        tick();
        vectors++;
        if (b0.ffrvld !== 1'b0 || b0.ffrdata !== 8'h05 || b0.ffrempty !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drained: got vld=%b data=%h empty=%b want vld=0 data=05 empty=1",
                     b0.ffrvld, b0.ffrdata, b0.ffrempty);
        end
    endtask

    task automatic test_wrap();
        drive0(0, 0, 8'h00, 0, 1);
        tick();
        drive0(0, 1, 8'h20, 0, 0);
        tick();
        drive0(0, 1, 8'h21, 0, 0);
        tick();
        for (int k = 0; k < 12; k++) begin
            drive0(0, 1, 8'(8'h22 + k), 1, 0);
            tick();
            vectors++;
            if (b0.ffvcnt !== 4'd2 || b0.ffrvld !== 1'b1 || b0.ffrdata !== 8'(8'h20 + k)) begin
                miscompares++;
                $display("FAIL wrap_%0d: got cnt=%0d vld=%b data=%h want cnt=2 vld=1 data=%h",
                         k, b0.ffvcnt, b0.ffrvld, b0.ffrdata, 8'(8'h20 + k));
            end
        end
        idle();
        vectors++;
        if (b0.ffovf !== 1'b0 || b0.ffudf !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_flags: got ovf=%b udf=%b want 0 0", b0.ffovf, b0.ffudf);
        end
    endtask

    task automatic test_underflow();
        drive0(0, 0, 8'h00, 1, 0);
        tick();
        tick();
        drive0(0, 1, 8'hA5, 1, 0);
        tick();
        idle();
        vectors++;
        if (b0.ffudf !== 1'b1 || b0.ffrvld !== 1'b0 || b0.ffvcnt !== 4'd1) begin
            miscompares++;
            $display("FAIL udf_no_wt: got udf=%b vld=%b cnt=%0d want udf=1 vld=0 cnt=1",
                     b0.ffudf, b0.ffrvld, b0.ffvcnt);
        end
        drive0(0, 0, 8'h00, 1, 0);
        tick();
        idle();
        vectors++;
        if (b0.ffrvld !== 1'b1 || b0.ffrdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL udf_next_read: got vld=%b data=%h want vld=1 data=a5", b0.ffrvld, b0.ffrdata);
        end
    endtask

    task automatic test_fwft();
        drive1(0, 1, 8'h11, 0, 0);
        tick();
        idle();
        vectors++;
        if (b1.ffrvld !== 1'b1 || b1.ffrdata !== 8'h11) begin
            miscompares++;
            $display("FAIL fwft_show: got vld=%b data=%h want vld=1 data=11", b1.ffrvld, b1.ffrdata);
        end
        drive1(0, 0, 8'h00, 1, 0);
        tick();
        idle();
        vectors++;
        if (b1.ffrvld !== 1'b0 || b1.ffrdata !== 8'h00) begin
            miscompares++;
            $display("FAIL fwft_pop: got vld=%b data=%h want vld=0 data=00", b1.ffrvld, b1.ffrdata);
        end
    endtask

    task automatic test_thresholds();
        for (int k = 0; k <= 5; k++) begin
            vectors++;
            if (b0.ffvcnt !== 4'(k) || b0.ffaempty !== (k <= AE) || b0.ffafull !== (k >= AF)) begin
                miscompares++;
                $display("FAIL thr_up%0d: got cnt=%0d ae=%b af=%b", k, b0.ffvcnt, b0.ffaempty, b0.ffafull);
            end
            if (k < 5) begin
                drive0(0, 1, 8'(8'h40 + k), 0, 0);
                tick();
            end
        end
        for (int k = 5; k >= 0; k--) begin
            vectors++;
            if (b0.ffvcnt !== 4'(k) || b0.ffaempty !== (k <= AE) || b0.ffafull !== (k >= AF)) begin
                miscompares++;
                $display("FAIL thr_down%0d: got cnt=%0d ae=%b af=%b", k, b0.ffvcnt, b0.ffaempty, b0.ffafull);
            end
            if (k > 0) begin
                drive0(0, 0, 8'h00, 1, 0);
                tick();
            end
        end
        idle();
    endtask

    task automatic test_flush();
        logic [18:0] rst_val;
        rst_val = {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 6; i++) begin
            drive0(0, 1, 8'(8'h60 + i), 0, 0);
            tick();
        end
        drive0(0, 0, 8'h00, 1, 0);
        tick();
        tick();
        drive0(1, 1, 8'hEE, 0, 0);
        tick();
        idle();
        vectors++;
        if (b0.ffvcnt !== 4'd0 || b0.ffrempty !== 1'b1 || b0.ffovf !== 1'b1 || b0.ffrvld !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: got cnt=%0d empty=%b ovf=%b vld=%b want cnt=0 empty=1 ovf=1 vld=0",
                     b0.ffvcnt, b0.ffrempty, b0.ffovf, b0.ffrvld);
        end
        drive0(0, 0, 8'h00, 0, 1);
        tick();
        idle();
        vectors++;
        if (b0.ffovf !== 1'b0) begin
            miscompares++;
            $display("FAIL errclr: got ovf=%b want 0", b0.ffovf);
        end
        drive0(0, 1, 8'h71, 0, 0);
        drive1(0, 1, 8'h72, 0, 0);
        tick();
        drive0(0, 1, 8'h73, 1, 0);
        drive1(0, 1, 8'h74, 0, 0);
        tick();
        reset = 1'b1;
        drive0(1, 1, 8'h75, 1, 1);
        drive1(0, 1, 8'h76, 1, 1);
        tick();
        reset = 1'b0;
        idle();
        vectors++;
        if (act0() !== rst_val) begin
            miscompares++;
            $display("FAIL midreset_dut0: got %h want %h", act0(), rst_val);
        end
        vectors++;
        if (act1() !== rst_val) begin
            miscompares++;
            $display("FAIL midreset_dut1: got %h want %h", act1(), rst_val);
        end
    endtask

    task automatic test_random();
        int wb, rb;
        for (int c = 0; c < 600; c++) begin
            wb = (c % 200 < 100) ? 70 : 30;
            rb = 100 - wb;
            reset = ($urandom_range(0, 199) == 0);
            drive0($urandom_range(0, 99) < 3, $urandom_range(0, 99) < wb, 8'($urandom),
                   $urandom_range(0, 99) < rb, $urandom_range(0, 99) < 5);
            drive1($urandom_range(0, 99) < 3, $urandom_range(0, 99) < rb, 8'($urandom),
                   $urandom_range(0, 99) < wb, $urandom_range(0, 99) < 5);
            tick();
            vectors++;
            if (act0() !== expv(0, q0, ovf0, udf0, rv0, rd0)) begin
                miscompares++;
                $display("FAIL rand_dut0 cyc%0d: got %h want %h", c, act0(), expv(0, q0, ovf0, udf0, rv0, rd0));
            end
            vectors++;
            if (act1() !== expv(1, q1, ovf1, udf1, rv1, rd1)) begin
                miscompares++;
                $display("FAIL rand_dut1 cyc%0d: got %h want %h", c, act1(), expv(1, q1, ovf1, udf1, rv1, rd1));
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_overflow();
        test_wrap();
        test_underflow();
        test_fwft();
        test_thresholds();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 Parameter DW, default 8: data width in bits, >= 1.
REQ-002 Parameter FD, default 8: depth in entries, >= 2, any integer (power of two not required).
REQ-003 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AF_LVL, default 6: almost-full threshold in entries.
REQ-005 Parameter AE_LVL, default 2: almost-empty threshold in entries.
REQ-006 Parameter legality SHALL be 0 <= AE_LVL < AF_LVL <= FD; any violation SHALL be an elaboration error.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 ffflush  in  1  discard all stored entries.
REQ-010 ffwreq  in  1  write request.
REQ-011 ffwdata  in  DW  write data.
REQ-012 ffwfull  out  1  occupancy == FD.
REQ-013 ffafull  out  1  occupancy >= AF_LVL.
REQ-014 ffrreq  in  1  read request (pop in FWFT mode).
REQ-015 ffrdata  out  DW  read data.
REQ-016 ffrvld  out  1  ffrdata valid.
REQ-017 ffrempty  out  1  occupancy == 0.
REQ-018 ffaempty  out  1  occupancy <= AE_LVL.
REQ-019 ffvcnt  out  $clog2(FD)+1  current occupancy.
REQ-020 ffovf  out  1  sticky overflow error.
REQ-021 ffudf  out  1  sticky underflow error.
REQ-022 fferrclr  in  1  clear ffovf and ffudf.

Function
REQ-023 Accepted write = ffwreq & ~ffwfull & ~ffflush; it stores ffwdata at wptr; wptr advances, wrapping from FD-1 to 0.
REQ-024 Write while ffwfull SHALL be dropped (no storage or pointer change) and SHALL set ffovf, even when a read is accepted in the same cycle.
REQ-025 Accepted read = ffrreq & ~ffrempty & ~ffflush; rptr advances, wrapping from FD-1 to 0.
REQ-026 Read while ffrempty SHALL be ignored and SHALL set ffudf, even when a write is accepted in the same cycle (no write-through).
REQ-027 ffvcnt: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither occur; it SHALL never exceed FD or go below 0.
REQ-028 ffwfull, ffafull, ffrempty and ffaempty SHALL be combinational decodes of the registered ffvcnt only.
REQ-029 FWFT=0: on an accepted read, ffrdata SHALL load the head entry and ffrvld SHALL be 1 in the next cycle. Otherwise ffrvld SHALL be 0 and ffrdata SHALL hold its value. Read latency is 1 cycle.
REQ-030 FWFT=1: ffrdata SHALL combinationally show the entry at rptr, with ffrvld = ~ffrempty. When empty, ffrdata SHALL be 0. An accepted read pops that entry and exposes the next entry in the following cycle.
REQ-031 ffflush SHALL, in the next cycle, set wptr, rptr and ffvcnt to 0 and set ffrvld to 0 (FWFT=0). It has priority over a same-cycle write or read: both are discarded, and neither sets an error flag.
REQ-032 ffflush SHALL NOT alter ffovf, ffudf or storage contents. In FWFT=0, ffrdata holds its value.
REQ-033 ffovf and ffudf SHALL remain 1 until fferrclr or reset. A same-cycle set condition SHALL win over fferrclr.
REQ-034 Storage SHALL be a DW x FD array addressed only by wptr and rptr; the wrap logic SHALL be correct for non-power-of-two FD.

Reset
REQ-035 While reset is high at a clock edge, next state SHALL be: wptr=0, rptr=0, ffvcnt=0, ffrdata=0, ffrvld=0, ffovf=0, ffudf=0. This gives ffrempty=1, ffwfull=0, ffafull=0, and ffaempty=1.
REQ-036 reset SHALL override ffflush, ffwreq, ffrreq and fferrclr in the same cycle. A reset in mid-operation SHALL discard all entries without setting error flags.
REQ-037 Storage contents need not be reset and SHALL never be observable before being written.

Verification
REQ-038 DW=8, FD=5, FWFT=0: write 0x01..0x05, then a 6th write of 0xFF -> ffwfull=1, ffovf=1, ffvcnt=5. Then read 5 times -> ffrdata 0x01..0x05 each one cycle after its ffrreq with ffrvld=1, and 0xFF is never returned.
REQ-039 FD=5: 12 cycles of simultaneous write+read starting at occupancy 2 -> ffvcnt stays 2, the data order is preserved across pointer wrap, and no error flags are set.
REQ-040 Empty FIFO, ffrreq=1 together with ffwreq=1 (data 0xA5) -> ffudf=1, ffrvld=0, and ffvcnt=1. The next read returns 0xA5.
REQ-041 FWFT=1: write 0x11 -> next cycle ffrvld=1 and ffrdata=0x11 with no ffrreq. Pop -> ffrvld=0 and ffrdata=0.
REQ-042 AF_LVL=4, AE_LVL=1: step occupancy 0 to 5 and back -> ffaempty=1 at 0..1, ffafull=1 at 4..5, and the transitions occur exactly on the ffvcnt edges.
REQ-043 Occupancy 3 with ffovf=1: assert ffflush with ffwreq=1 -> ffvcnt=0, ffrempty=1, ffovf still 1. Then assert fferrclr -> ffovf=0. Then assert reset mid-stream -> all outputs match REQ-035.
